// File: rtl/mux8_arb_pkg.sv
// ---------------------------------------------------------------------------
// mux8_arb_pkg
// Shared definitions for the 8-requester round-robin byte arbiter:
//   N_REQ / SEL_W  - requester count and select width
//   arb_state_e    - arbiter FSM state
//   rr_pick()      - round-robin search starting just after a pointer
// ---------------------------------------------------------------------------
package mux8_arb_pkg;

  localparam int N_REQ = 8;
  localparam int SEL_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // First set bit of req scanning ptr+1, ptr+2, ... with wrap-around; ptr
  // itself is the last candidate, so a sole requester can win again.
  // Returns ptr when req is empty (callers only use it when |req).
  function automatic logic [SEL_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                               input logic [SEL_W-1:0] ptr);
    logic [SEL_W-1:0] idx;
    logic             found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = ptr + SEL_W'(k);
      if (req[idx] && !found) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/mux8_rr_arbiter_mux8.sv
// ---------------------------------------------------------------------------
// mux8
// Plain 8:1 byte multiplexer forming the shared datapath.
// Ports:
//   in0..in7  in  8  candidate bytes
//   select    in  3  index of the byte to pass
//   y         out 8  selected byte
// ---------------------------------------------------------------------------
module mux8 (
  input  logic [7:0] in0,
  input  logic [7:0] in1,
  input  logic [7:0] in2,
  input  logic [7:0] in3,
  input  logic [7:0] in4,
  input  logic [7:0] in5,
  input  logic [7:0] in6,
  input  logic [7:0] in7,
  input  logic [2:0] select,
  output logic [7:0] y
);

  always_comb begin
    case (select)
      3'd0:    y = in0;
      3'd1:    y = in1;
      3'd2:    y = in2;
      3'd3:    y = in3;
      3'd4:    y = in4;
      3'd5:    y = in5;
      3'd6:    y = in6;
      default: y = in7;
    endcase
  end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux8_rr_arbiter
// Round-robin arbiter sharing one 8:1 byte mux between 8 requesters and
// forwarding the granted byte downstream over valid/ready. A requester may
// hold lock to keep the grant for up to MAX_HOLD consecutive beats.
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous active-high reset
//   req        in   8      byte pending per requester
//   lock       in   8      keep-grant request per requester
//   in_data    in   8x8    byte per requester
//   in_ack     out  8      combinational one-hot beat acceptance
//   gnt        out  8      registered one-hot grant, 0 when idle
//   sel        out  3      registered mux select
//   out_valid  out  1      downstream byte valid
//   out_ready  in   1      downstream accepts byte
//   out_data   out  8      granted byte, 0 when not valid
//   out_src    out  3      source index of out_data
// ---------------------------------------------------------------------------
module mux8_rr_arbiter
  import mux8_arb_pkg::*;
#(
  parameter int MAX_HOLD = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ-1:0]       lock,
  input  logic [N_REQ-1:0][7:0]  in_data,
  output logic [N_REQ-1:0]       in_ack,
  output logic [N_REQ-1:0]       gnt,
  output logic [SEL_W-1:0]       sel,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [7:0]             out_data,
  output logic [SEL_W-1:0]       out_src
);

  localparam int                HOLD_W     = $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX_C = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_ONE   = HOLD_W'(1);

  arb_state_e        r_state, w_state_nxt;
  logic [SEL_W-1:0]  r_ptr,   w_ptr_nxt;
  logic [SEL_W-1:0]  r_sel,   w_sel_nxt;
  logic [HOLD_W-1:0] r_hold_cnt, w_hold_nxt;
  logic [N_REQ-1:0]  r_gnt,   w_gnt_nxt;
  logic [7:0]        w_mux_y;
  logic              w_done;
  logic              w_keep;

  // NOTE: every variable driven here gets a default first so no path leaves
  // it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_sel_nxt   = r_sel;
    w_hold_nxt  = r_hold_cnt;
    w_gnt_nxt   = r_gnt;
    in_ack      = '0;
    w_done      = (r_state == BUSY) && out_ready;
    w_keep      = lock[r_sel] && req[r_sel] && (r_hold_cnt < HOLD_MAX_C);

    case (r_state)
      IDLE: begin
        if (|req) begin
          w_state_nxt = BUSY;
          w_sel_nxt   = rr_pick(req, r_ptr);
          w_gnt_nxt   = N_REQ'(1) << w_sel_nxt;
          w_hold_nxt  = HOLD_ONE;
        end
      end
      BUSY: begin
        // While stalled nothing moves; req[sel] is trusted to stay high.
        if (w_done) begin
          in_ack    = r_gnt;
          w_ptr_nxt = r_sel;
          if (w_keep) begin
            w_hold_nxt = r_hold_cnt + HOLD_ONE;
          end else if (|req) begin
            // Pick the next beat in the ack cycle so there is no bubble.
            w_sel_nxt  = rr_pick(req, r_sel);
            w_gnt_nxt  = N_REQ'(1) << w_sel_nxt;
            w_hold_nxt = HOLD_ONE;
          end else begin
            w_state_nxt = IDLE;
            w_gnt_nxt   = '0;
            w_hold_nxt  = '0;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    // A beat under reset is aborted, so it must not be acknowledged.
    if (rst) in_ack = '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_ptr      <= SEL_W'(N_REQ - 1);
      r_sel      <= '0;
      r_hold_cnt <= '0;
      r_gnt      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_sel      <= w_sel_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_gnt      <= w_gnt_nxt;
    end
  end

  mux8 u_mux8 (
    .in0    (in_data[0]),
    .in1    (in_data[1]),
    .in2    (in_data[2]),
    .in3    (in_data[3]),
    .in4    (in_data[4]),
    .in5    (in_data[5]),
    .in6    (in_data[6]),
    .in7    (in_data[7]),
    .select (r_sel),
    .y      (w_mux_y)
  );

  assign out_valid = (r_state == BUSY);
  assign out_data  = out_valid ? w_mux_y : 8'h00;
  assign out_src   = r_sel;
  assign sel       = r_sel;
  assign gnt       = r_gnt;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mux8_rr_arbiter
// Directed bench for mux8_rr_arbiter (MAX_HOLD=4). Expected beats are queued
// as stimulus is applied and popped by a monitor on every accepted beat;
// per-cycle grant/ack behaviour is checked inline.
// ---------------------------------------------------------------------------
module tb_mux8_rr_arbiter;

  typedef struct packed {
    logic [2:0] src;
    logic [7:0] data;
  } beat_t;

  logic             clk;
  logic             rst;
  logic [7:0]       req;
  logic [7:0]       lock;
  logic [7:0][7:0]  in_data;
  logic [7:0]       in_ack;
  logic [7:0]       gnt;
  logic [2:0]       sel;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_data;
  logic [2:0]       out_src;

  beat_t sb_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  mux8_rr_arbiter #(.MAX_HOLD(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .lock      (lock),
    .in_data   (in_data),
    .in_ack    (in_ack),
    .gnt       (gnt),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] data_of(input int i);
    return 8'(i * 17 + 3);
  endfunction

  task automatic push_beat(input int src);
    beat_t b;
    b.src  = 3'(src);
    b.data = data_of(src);
    sb_q.push_back(b);
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    req = '0;
    lock = '0;
    out_ready = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic check_grant(input string tag, input int exp_src);
    @(negedge clk);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_sel"},   32'(sel),       32'(exp_src));
    check({tag, "_gnt"},   32'(gnt),       32'(8'b1 << exp_src));
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_gnt"},   32'(gnt),       32'd0);
    check({tag, "_data"},  32'(out_data),  32'd0);
    check({tag, "_ack"},   32'(in_ack),    32'd0);
  endtask

  // Scoreboard: every accepted beat must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      beat_t b;
      check("sb_pending", 32'(sb_q.size() > 0), 32'd1);
      if (sb_q.size() > 0) begin
        b = sb_q.pop_front();
        check("sb_src",  32'(out_src),  32'(b.src));
        check("sb_data", 32'(out_data), 32'(b.data));
        check("sb_ack",  32'(in_ack),   32'(8'b1 << b.src));
      end
    end
  end

  initial begin
    int t2_seq[10];
    int t4_seq[6];
    int t6_seq[6];
    t2_seq = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1};
    t4_seq = '{0, 0, 0, 0, 1, 0};
    t6_seq = '{5, 5, 5, 5, 2, 5};

    for (int i = 0; i < 8; i++) in_data[i] = data_of(i);
    rst = 1'b1;
    req = '0;
    lock = '0;
    out_ready = 1'b0;
    cyc();
    cyc();

    // Reset state, observed while reset is still asserted.
    @(negedge clk);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_gnt",   32'(gnt),       32'd0);
    check("rst_sel",   32'(sel),       32'd0);
    check("rst_data",  32'(out_data),  32'd0);
    check("rst_ack",   32'(in_ack),    32'd0);
    cyc();
    rst = 1'b0;

    // T1: single beat from requester 0, one cycle of latency.
    in_data[0] = 8'hA5;
    req = 8'h01;
    out_ready = 1'b1;
    sb_q.push_back('{src: 3'd0, data: 8'hA5});
    @(negedge clk);
    check("t1_idle_valid", 32'(out_valid), 32'd0);
    cyc();
    req = 8'h00;
    @(negedge clk);
    check("t1_valid", 32'(out_valid), 32'd1);
    check("t1_sel",   32'(sel),       32'd0);
    check("t1_data",  32'(out_data),  32'hA5);
    check("t1_ack",   32'(in_ack),    32'h01);
    cyc();
    check_idle("t1_end");
    in_data[0] = data_of(0);

    // T2: all requesting, strict rotation with no bubbles.
    apply_reset();
    req = 8'hFF;
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) push_beat(t2_seq[k]);
    for (int k = 0; k < 10; k++) begin
      cyc();
      if (k == 9) req = 8'h00;
      check_grant("t2", t2_seq[k]);
    end
    cyc();
    check_idle("t2_end");

    // T3: downstream stall for three cycles.
    apply_reset();
    req = 8'h04;
    out_ready = 1'b0;
    push_beat(2);
    for (int k = 0; k < 3; k++) begin
      cyc();
      check_grant("t3_stall", 2);
      check("t3_stall_ack", 32'(in_ack), 32'd0);
    end
    cyc();
    out_ready = 1'b1;
    req = 8'h00;
    @(negedge clk);
    check("t3_ack", 32'(in_ack), 32'h04);
    cyc();
    check_idle("t3_end");

    // T4: lock bounded by MAX_HOLD, then round robin resumes.
    apply_reset();
    req = 8'h03;
    lock = 8'h01;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) push_beat(t4_seq[k]);
    for (int k = 0; k < 6; k++) begin
      cyc();
      if (k == 5) begin
        req = 8'h00;
        lock = 8'h00;
      end
      check_grant("t4", t4_seq[k]);
    end
    cyc();
    check_idle("t4_end");

    // T5: reset while requester 3 is mid-beat.
    apply_reset();
    req = 8'hFF;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) push_beat(k);
    for (int k = 0; k < 3; k++) begin
      cyc();
      check_grant("t5", k);
    end
    cyc();
    rst = 1'b1;
    @(negedge clk);
    check("t5_pre_sel", 32'(sel),    32'd3);
    check("t5_rst_ack", 32'(in_ack), 32'd0);
    cyc();
    rst = 1'b0;
    @(negedge clk);
    check("t5_post_valid", 32'(out_valid), 32'd0);
    check("t5_post_gnt",   32'(gnt),       32'd0);
    push_beat(0);
    cyc();
    req = 8'h00;
    check_grant("t5_first", 0);
    cyc();
    check_idle("t5_end");

    // T6: sole requester streams, a newcomer gets exactly one turn.
    apply_reset();
    req = 8'h20;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) push_beat(t6_seq[k]);
    for (int k = 0; k < 6; k++) begin
      cyc();
      if (k == 3) req = 8'h24;
      if (k == 5) req = 8'h00;
      check_grant("t6", t6_seq[k]);
      check("t6_src", 32'(out_src), 32'(t6_seq[k]));
    end
    cyc();
    check_idle("t6_end");

    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
